// File: rtl/awgn_pkg.sv
// Shared constants and types for the AWGN noise-path arithmetic blocks.
// The antilog stage reuses the log unit's code offset and its 5/7 scale.
package awgn_pkg;

  localparam int W_OUT   = 48;
  localparam int LOG_OFS = 44;
  localparam int NUM     = 5;
  localparam int DEN     = 7;

  localparam int IDX_W = 6;   // holds p in 0..W_OUT-1
  localparam int D_W   = 9;   // signed d = LOG_OFS - log_in, range -83..172
  localparam int NUM_W = 10;  // d*NUM, at most 860
  localparam int QUO_W = 7;   // quotient, at most 122
  localparam int REM_W = 3;   // remainder, below DEN
  localparam int CNT_W = 4;   // enough for NUM_W-1 down-counting steps

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [W_OUT-1:0] MSB_ONE = {1'b1, {(W_OUT-1){1'b0}}};

  // One-hot magnitude whose single set bit sits p places below the MSB.
  function automatic logic [W_OUT-1:0] onehot_from_msb(input logic [IDX_W-1:0] p);
    return MSB_ONE >> p;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Sequential restoring divider by the constant DEN: one quotient bit per
// cycle, MSB first, NUM_W cycles per division.
module seq_udiv
  import awgn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient,
  output logic [REM_W-1:0] remainder
);

  logic [CNT_W-1:0] cnt_q;
  logic [NUM_W-1:0] quo_q;
  logic [REM_W-1:0] rem_q;

  logic [REM_W:0]   shifted;
  logic [REM_W:0]   diff;
  logic             fits;
  logic [REM_W-1:0] rem_nxt;
  logic [NUM_W-1:0] quo_nxt;
  logic             unused_bits;

  // The dividend shifts out of the top of quo_q while quotient bits enter at the bottom.
  assign shifted = {rem_q, quo_q[NUM_W-1]};
  assign diff    = shifted - (REM_W+1)'(DEN);
  assign fits    = shifted >= (REM_W+1)'(DEN);
  assign rem_nxt = fits ? diff[REM_W-1:0] : shifted[REM_W-1:0];
  assign quo_nxt = {quo_q[NUM_W-2:0], fits};

  // Results are the post-step values, so they are complete in the cycle done is high.
  assign done      = busy & (cnt_q == '0);
  assign quotient  = quo_nxt[QUO_W-1:0];
  assign remainder = rem_nxt;

  // A quotient of 860/7 never reaches the upper bits; diff's MSB is only a borrow.
  assign unused_bits = ^{quo_nxt[NUM_W-1:QUO_W], diff[REM_W]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= CNT_W'(NUM_W - 1);
      quo_q <= dividend;
      rem_q <= '0;
    end else if (busy) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      if (cnt_q == '0) busy <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/antilog_seq.sv
// Approximate antilog: turns a log code back into a one-hot 48-bit magnitude
// via p = floor((LOG_OFS - L) * 5 / 7), with valid/ready on both sides.
module antilog_seq
  import awgn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       log_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] exp_out,
  output logic [IDX_W-1:0] idx_out,
  output logic             clamp
);

  state_t           state_q;
  logic [D_W-1:0]   d_q;
  logic             neg_q;

  logic [NUM_W-1:0] num_c;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [QUO_W-1:0] div_quo;
  logic [REM_W-1:0] div_rem;
  logic             unused_div;

  logic             over_c;
  logic [IDX_W-1:0] p_c;

  // d is at most 172 when non-negative, so its low 8 bits are the magnitude; x5 = x4 + x1.
  assign num_c = d_q[D_W-1] ? '0
                            : ({d_q[D_W-2:0], 2'b00} + {2'b00, d_q[D_W-2:0]});

  assign div_start = (state_q == MUL);

  seq_udiv u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (num_c),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign unused_div = ^{div_busy, div_rem};

  assign over_c = div_quo > QUO_W'(W_OUT - 1);
  assign p_c    = neg_q  ? '0
                : over_c ? IDX_W'(W_OUT - 1)
                :          div_quo[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      neg_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      exp_out   <= '0;
      idx_out   <= '0;
      clamp     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q      <= D_W'(LOG_OFS) - {log_in[7], log_in};
            in_ready <= 1'b0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          neg_q   <= d_q[D_W-1];
          state_q <= DIV;
        end
        DIV: begin
          if (div_done) begin
            exp_out   <= onehot_from_msb(p_c);
            idx_out   <= p_c;
            clamp     <= neg_q | over_c;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Results stay registered after the handshake until the next DONE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
